// File: rtl/serv_decode_fifo.sv
// Decoded instruction queue: decodes each fetched word on enqueue and presents the head entry's flags.
// Optional SERV_DECODE_ILLEGAL_EN adds per-entry illegal-opcode tracking (o_illegal, o_illegal_seen).
module serv_decode_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned MDU   = 0
) (
  input  logic                     clk,
  input  logic                     i_rst,
  input  logic [29:0]              i_wb_rdt,
  input  logic                     i_wb_en,
  output logic                     o_ready,
  input  logic                     i_flush,
  input  logic                     i_take,
  output logic                     o_valid,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic [4:0]               o_opcode,
  output logic [2:0]               o_funct3,
  output logic                     o_rd_op,
  output logic                     o_two_stage_op,
  output logic                     o_shift_op,
  output logic                     o_branch_op,
  output logic                     o_dbus_en,
  output logic                     o_mdu_op,
  output logic                     o_csr_op,
  output logic                     o_e_op,
  output logic                     o_mret
`ifdef SERV_DECODE_ILLEGAL_EN
  ,
  output logic                     o_illegal,
  output logic                     o_illegal_seen
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam bit MDU_EN = (MDU != 0);

  typedef struct packed {
    logic [4:0] opcode;
    logic [2:0] funct3;
    logic       rd_op;
    logic       two_stage_op;
    logic       shift_op;
    logic       branch_op;
    logic       dbus_en;
    logic       mdu_op;
    logic       csr_op;
    logic       e_op;
    logic       mret;
`ifdef SERV_DECODE_ILLEGAL_EN
    logic       illegal;
`endif
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        wr_entry;
  entry_t        head;
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [LW-1:0] level;
  logic          enq;
  logic          deq;

  // Instruction fields; i_wb_rdt[k-2] holds instruction bit k
  logic [4:0] op;
  logic [2:0] f3;
  logic       b21;
  logic       b25;
  logic       mdu_op;
  logic       unused_rdt;

  assign op     = i_wb_rdt[4:0];
  assign f3     = i_wb_rdt[12:10];
  assign b21    = i_wb_rdt[19];
  assign b25    = i_wb_rdt[23];
  assign mdu_op = MDU_EN & (op == 5'b01100) & b25;
  assign unused_rdt = &{i_wb_rdt[29:24], i_wb_rdt[22:20], i_wb_rdt[18:13], i_wb_rdt[9:5], 1'b0};

  // Decode the incoming word into the stored bundle
  always_comb begin
    wr_entry              = '0;
    wr_entry.opcode       = op;
    wr_entry.funct3       = f3;
    wr_entry.rd_op        = op[2] | (op[4] & op[0]) | (~op[2] & ~op[3] & ~op[0]);
    wr_entry.two_stage_op = ~op[2] | (f3[0] & ~f3[1] & ~op[0] & ~op[4])
                          | (f3[1] & ~f3[2] & ~op[0] & ~op[4]) | mdu_op;
    wr_entry.shift_op     = op[2] & ~f3[1] & ~mdu_op;
    wr_entry.branch_op    = op[4];
    wr_entry.dbus_en      = ~op[2] & ~op[4];
    wr_entry.mdu_op       = mdu_op;
    wr_entry.csr_op       = op[4] & op[2] & (|f3);
    wr_entry.e_op         = op[4] & op[2] & ~b21 & ~(|f3);
    wr_entry.mret         = op[4] & op[2] & b21 & ~(|f3);
`ifdef SERV_DECODE_ILLEGAL_EN
    case (op)
      5'b00000, 5'b00011, 5'b00100, 5'b00101, 5'b01000, 5'b01100,
      5'b01101, 5'b11000, 5'b11001, 5'b11011, 5'b11100:
        wr_entry.illegal = (op == 5'b01100) & b25 & ~MDU_EN;
      default:
        wr_entry.illegal = 1'b1;
    endcase
`endif
  end

  assign o_ready = (level != LW'(DEPTH));
  assign o_valid = (level != '0);
  assign o_level = level;
  assign enq     = i_wb_en & o_ready;
  assign deq     = i_take & o_valid;

  // Pointers and occupancy; flush overrides any concurrent write or take
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else if (i_flush) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (enq) wptr <= wptr + PW'(1);
      if (deq) rptr <= rptr + PW'(1);
      level <= level + LW'(enq) - LW'(deq);
    end
  end

  // Entry storage carries no reset; occupancy alone defines validity
  always_ff @(posedge clk) begin
    if (enq && !i_flush) mem[wptr] <= wr_entry;
  end

  always_comb begin
    head = '0;
    if (o_valid) head = mem[rptr];
  end

  assign o_opcode       = head.opcode;
  assign o_funct3       = head.funct3;
  assign o_rd_op        = head.rd_op;
  assign o_two_stage_op = head.two_stage_op;
  assign o_shift_op     = head.shift_op;
  assign o_branch_op    = head.branch_op;
  assign o_dbus_en      = head.dbus_en;
  assign o_mdu_op       = head.mdu_op;
  assign o_csr_op       = head.csr_op;
  assign o_e_op         = head.e_op;
  assign o_mret         = head.mret;

`ifdef SERV_DECODE_ILLEGAL_EN
  logic illegal_seen;

  // Sticky once an illegal head has been consumed
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      illegal_seen <= 1'b0;
    end else if (i_flush) begin
      illegal_seen <= 1'b0;
    end else if (deq && head.illegal) begin
      illegal_seen <= 1'b1;
    end
  end

  assign o_illegal      = head.illegal;
  assign o_illegal_seen = illegal_seen;
`endif

endmodule

// File: tb/tb_serv_decode_fifo.sv
// Bench for serv_decode_fifo: two instances (MDU=0 and MDU=1) share stimulus and are compared
// against a queue-of-instructions model that decodes the head word on demand.
module tb_serv_decode_fifo;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        i_rst;
  logic [29:0] i_wb_rdt;
  logic        i_wb_en;
  logic        i_flush;
  logic        i_take;

  logic        d0_ready, d0_valid, d1_ready, d1_valid;
  logic [2:0]  d0_level, d1_level;
  logic [4:0]  d0_opcode, d1_opcode;
  logic [2:0]  d0_funct3, d1_funct3;
  logic        d0_rd_op, d0_two_stage_op, d0_shift_op, d0_branch_op, d0_dbus_en;
  logic        d0_mdu_op, d0_csr_op, d0_e_op, d0_mret;
  logic        d1_rd_op, d1_two_stage_op, d1_shift_op, d1_branch_op, d1_dbus_en;
  logic        d1_mdu_op, d1_csr_op, d1_e_op, d1_mret;
  logic        d0_illegal, d0_illegal_seen, d1_illegal, d1_illegal_seen;
  logic [16:0] d0_vec, d1_vec;

  assign d0_vec = {d0_opcode, d0_funct3, d0_rd_op, d0_two_stage_op, d0_shift_op, d0_branch_op,
                   d0_dbus_en, d0_mdu_op, d0_csr_op, d0_e_op, d0_mret};
  assign d1_vec = {d1_opcode, d1_funct3, d1_rd_op, d1_two_stage_op, d1_shift_op, d1_branch_op,
                   d1_dbus_en, d1_mdu_op, d1_csr_op, d1_e_op, d1_mret};

`ifndef SERV_DECODE_ILLEGAL_EN
  assign d0_illegal = 1'b0;
  assign d0_illegal_seen = 1'b0;
  assign d1_illegal = 1'b0;
  assign d1_illegal_seen = 1'b0;
`endif

  serv_decode_fifo #(.DEPTH(DEPTH), .MDU(0)) dut0 (
    .clk(clk), .i_rst(i_rst), .i_wb_rdt(i_wb_rdt), .i_wb_en(i_wb_en), .o_ready(d0_ready),
    .i_flush(i_flush), .i_take(i_take), .o_valid(d0_valid), .o_level(d0_level),
    .o_opcode(d0_opcode), .o_funct3(d0_funct3), .o_rd_op(d0_rd_op),
    .o_two_stage_op(d0_two_stage_op), .o_shift_op(d0_shift_op), .o_branch_op(d0_branch_op),
    .o_dbus_en(d0_dbus_en), .o_mdu_op(d0_mdu_op), .o_csr_op(d0_csr_op), .o_e_op(d0_e_op),
    .o_mret(d0_mret)
`ifdef SERV_DECODE_ILLEGAL_EN
    , .o_illegal(d0_illegal), .o_illegal_seen(d0_illegal_seen)
`endif
  );

  serv_decode_fifo #(.DEPTH(DEPTH), .MDU(1)) dut1 (
    .clk(clk), .i_rst(i_rst), .i_wb_rdt(i_wb_rdt), .i_wb_en(i_wb_en), .o_ready(d1_ready),
    .i_flush(i_flush), .i_take(i_take), .o_valid(d1_valid), .o_level(d1_level),
    .o_opcode(d1_opcode), .o_funct3(d1_funct3), .o_rd_op(d1_rd_op),
    .o_two_stage_op(d1_two_stage_op), .o_shift_op(d1_shift_op), .o_branch_op(d1_branch_op),
    .o_dbus_en(d1_dbus_en), .o_mdu_op(d1_mdu_op), .o_csr_op(d1_csr_op), .o_e_op(d1_e_op),
    .o_mret(d1_mret)
`ifdef SERV_DECODE_ILLEGAL_EN
    , .o_illegal(d1_illegal), .o_illegal_seen(d1_illegal_seen)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [29:0] q[$];
  bit seen0, seen1;

  localparam logic [4:0] OP_TAB [14] = '{5'b00000, 5'b00011, 5'b00100, 5'b00101, 5'b01000,
                                        5'b01100, 5'b01101, 5'b11000, 5'b11001, 5'b11011,
                                        5'b11100, 5'b00010, 5'b11111, 5'b01011};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected decoded bundle from the full 32-bit instruction word
  function automatic logic [16:0] dec(input logic [29:0] w, input bit mdu);
    logic [31:0] ins;
    logic [4:0]  op;
    logic [2:0]  f;
    logic        m;
    ins = {w, 2'b11};
    op  = ins[6:2];
    f   = ins[14:12];
    m   = mdu && (op == 5'b01100) && ins[25];
    return {op, f,
            op[2] | (op[4] & op[0]) | (~op[2] & ~op[3] & ~op[0]),
            ~op[2] | (f[0] & ~f[1] & ~op[0] & ~op[4]) | (f[1] & ~f[2] & ~op[0] & ~op[4]) | m,
            op[2] & ~f[1] & ~m,
            op[4],
            ~op[2] & ~op[4],
            m,
            op[4] & op[2] & (|f),
            op[4] & op[2] & ~ins[21] & ~(|f),
            op[4] & op[2] & ins[21] & ~(|f)};
  endfunction

  function automatic bit ill(input logic [29:0] w, input bit mdu);
    logic [4:0] op;
    op = w[4:0];
    if (!(op inside {5'b00000, 5'b00011, 5'b00100, 5'b00101, 5'b01000, 5'b01100,
                     5'b01101, 5'b11000, 5'b11001, 5'b11011, 5'b11100})) return 1'b1;
    return (op == 5'b01100) && w[23] && !mdu;
  endfunction

  task automatic check_all();
    int n;
    n = q.size();
    chk("level0", 32'(d0_level), 32'(n));
    chk("level1", 32'(d1_level), 32'(n));
    chk("valid0", 32'(d0_valid), 32'(n != 0));
    chk("ready0", 32'(d0_ready), 32'(n != DEPTH));
    chk("valid1", 32'(d1_valid), 32'(n != 0));
    chk("ready1", 32'(d1_ready), 32'(n != DEPTH));
    chk("flags0", 32'(d0_vec), (n != 0) ? 32'(dec(q[0], 1'b0)) : 32'd0);
    chk("flags1", 32'(d1_vec), (n != 0) ? 32'(dec(q[0], 1'b1)) : 32'd0);
`ifdef SERV_DECODE_ILLEGAL_EN
    chk("illegal0", 32'(d0_illegal), (n != 0) ? 32'(ill(q[0], 1'b0)) : 32'd0);
    chk("illegal1", 32'(d1_illegal), (n != 0) ? 32'(ill(q[0], 1'b1)) : 32'd0);
    chk("seen0", 32'(d0_illegal_seen), 32'(seen0));
    chk("seen1", 32'(d1_illegal_seen), 32'(seen1));
`endif
  endtask

  // One clock: update the model with the inputs seen at the edge, then compare
  task automatic step();
    bit rdy, vld;
    logic [29:0] hd;
    @(posedge clk);
    rdy = (q.size() != DEPTH);
    vld = (q.size() != 0);
    if (i_rst || i_flush) begin
      q.delete();
      seen0 = 1'b0;
      seen1 = 1'b0;
    end else begin
      if (i_take && vld) begin
        hd = q.pop_front();
        if (ill(hd, 1'b0)) seen0 = 1'b1;
        if (ill(hd, 1'b1)) seen1 = 1'b1;
      end
      if (i_wb_en && rdy) q.push_back(i_wb_rdt);
    end
    #1;
    check_all();
  endtask

  task automatic cyc(input bit en, input logic [29:0] w, input bit tk, input bit fl);
    i_wb_en  = en;
    i_wb_rdt = w;
    i_take   = tk;
    i_flush  = fl;
    step();
  endtask

  function automatic logic [29:0] rand_word();
    logic [29:0] w;
    w = 30'($urandom);
    w[4:0] = OP_TAB[$urandom_range(0, 13)];
    return w;
  endfunction

  initial begin
    i_rst = 1'b1; i_wb_rdt = '0; i_wb_en = 1'b0; i_flush = 1'b0; i_take = 1'b0;
    #1;
    chk("rst_valid", 32'(d0_valid), 32'd0);
    chk("rst_ready", 32'(d0_ready), 32'd1);
    chk("rst_level", 32'(d0_level), 32'd0);
    @(posedge clk); #1;
    i_rst = 1'b0;

    // addi x1,x0,5 into empty queue
    cyc(1'b1, 30'h00140024, 1'b0, 1'b0);
    chk("addi_valid", 32'(d0_valid), 32'd1);
    chk("addi_opcode", 32'(d0_opcode), 32'h04);
    chk("addi_rd", 32'(d0_rd_op), 32'd1);
    chk("addi_shift", 32'(d0_shift_op), 32'd1);
    chk("addi_two", 32'(d0_two_stage_op), 32'd0);
    chk("addi_level", 32'(d0_level), 32'd1);

    // Fill past full, then one take
    cyc(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b1, rand_word(), 1'b0, 1'b0);
    chk("full_level", 32'(d0_level), 32'd4);
    chk("full_ready", 32'(d0_ready), 32'd0);
    cyc(1'b1, rand_word(), 1'b1, 1'b0);
    chk("take_level", 32'(d0_level), 32'd3);
    chk("take_ready", 32'(d0_ready), 32'd1);

    // Flush wins over concurrent write and take
    cyc(1'b0, '0, 1'b0, 1'b1);
    cyc(1'b1, rand_word(), 1'b0, 1'b0);
    cyc(1'b1, rand_word(), 1'b0, 1'b0);
    cyc(1'b1, rand_word(), 1'b1, 1'b1);
    chk("flush_level", 32'(d0_level), 32'd0);
    chk("flush_valid", 32'(d0_valid), 32'd0);
    chk("flush_flags", 32'(d0_vec), 32'd0);

    // mul with and without M-extension
    cyc(1'b1, 30'h008C402C, 1'b0, 1'b0);
    chk("mul_mdu1", 32'(d1_mdu_op), 32'd1);
    chk("mul_two1", 32'(d1_two_stage_op), 32'd1);
    chk("mul_shift1", 32'(d1_shift_op), 32'd0);
    chk("mul_mdu0", 32'(d0_mdu_op), 32'd0);
`ifdef SERV_DECODE_ILLEGAL_EN
    chk("mul_ill0", 32'(d0_illegal), 32'd1);
    chk("mul_ill1", 32'(d1_illegal), 32'd0);
`endif

    // Asynchronous reset between edges with three entries queued
    cyc(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b1, rand_word(), 1'b0, 1'b0);
    i_wb_en = 1'b0;
    i_rst = 1'b1;
    #1;
    chk("arst_valid", 32'(d0_valid), 32'd0);
    chk("arst_level", 32'(d0_level), 32'd0);
    chk("arst_ready", 32'(d0_ready), 32'd1);
    q.delete(); seen0 = 1'b0; seen1 = 1'b0;
    #1;
    i_rst = 1'b0;
    cyc(1'b1, 30'h00140024, 1'b0, 1'b0);
    chk("post_rst_level", 32'(d0_level), 32'd1);

`ifdef SERV_DECODE_ILLEGAL_EN
    // Illegal word taken sets the sticky flag until flush
    cyc(1'b0, '0, 1'b0, 1'b1);
    cyc(1'b1, 30'h00000002, 1'b0, 1'b0);
    chk("ill_head", 32'(d0_illegal), 32'd1);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("ill_seen", 32'(d0_illegal_seen), 32'd1);
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b0, 1'b0);
    chk("ill_sticky", 32'(d0_illegal_seen), 32'd1);
    cyc(1'b0, '0, 1'b0, 1'b1);
    chk("ill_clear", 32'(d0_illegal_seen), 32'd0);
`endif

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 99) < 60, rand_word(), $urandom_range(0, 99) < 50,
          $urandom_range(0, 40) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
